// File: rtl/line_tracker_ctrl.sv
// line_tracker_ctrl: line-following decision block for the car.
// Takes N active-low IR track sensors, synchronises and filters them, then an
// FSM produces the 2-bit motion command (00 stop, 01 right, 10 left, 11 straight)
// with lost-line search, timeout to HALT and last-turn memory.
// Optional feature macro: LINE_TRACKER_DEBOUNCE_EN (defined = per-bit debounce
// filter built; undefined = filter bypassed, DEBOUNCE ignored).
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   track      raw sensor bits, 0 = line under sensor, [N-1] is leftmost
//   start_move run enable, low forces IDLE
//   state      motion command (registered)
//   pre_state  last turn direction taken, 01 or 10 (registered)
//   lost       high only in HALT (registered)
//   line_mask  filtered line-present mask, 1 = line (registered)
module line_tracker_ctrl #(
    parameter int unsigned N_SENSORS    = 3,
    parameter int unsigned DEBOUNCE     = 4,
    parameter int unsigned LOST_TIMEOUT = 1000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_SENSORS-1:0] track,
    input  logic                 start_move,
    output logic [1:0]           state,
    output logic [1:0]           pre_state,
    output logic                 lost,
    output logic [N_SENSORS-1:0] line_mask
);

    localparam int unsigned CENTER = (N_SENSORS - 1) / 2;
    localparam int unsigned LC_W   = $clog2(LOST_TIMEOUT + 1);
    localparam int unsigned SC_W   = 3;

    localparam logic [1:0] MOT_STOP  = 2'b00;
    localparam logic [1:0] MOT_RIGHT = 2'b01;
    localparam logic [1:0] MOT_LEFT  = 2'b10;
    localparam logic [1:0] MOT_STR   = 2'b11;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_STRAIGHT = 3'd1;
    localparam logic [2:0] S_LEFT     = 3'd2;
    localparam logic [2:0] S_RIGHT    = 3'd3;
    localparam logic [2:0] S_SEARCH   = 3'd4;
    localparam logic [2:0] S_HALT     = 3'd5;

    // Elaboration-time parameter range checks
    if ((N_SENSORS % 2) == 0 || N_SENSORS < 3 || N_SENSORS > 7) begin : g_bad_n
        $error("line_tracker_ctrl: N_SENSORS must be odd, 3..7");
    end
    if (DEBOUNCE < 1 || DEBOUNCE > 255) begin : g_bad_db
        $error("line_tracker_ctrl: DEBOUNCE must be 1..255");
    end
    if (LOST_TIMEOUT < 1) begin : g_bad_to
        $error("line_tracker_ctrl: LOST_TIMEOUT must be >= 1");
    end

    // Two-flop synchronisers; sensors are inverted first so 1 = line everywhere downstream
    logic [N_SENSORS-1:0] line_s1_q, line_s2_q;
    logic                 start_s1_q, start_s2_q;
    logic [N_SENSORS-1:0] mask_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_s1_q  <= '0;
            line_s2_q  <= '0;
            start_s1_q <= 1'b0;
            start_s2_q <= 1'b0;
        end else begin
            line_s1_q  <= ~track;
            line_s2_q  <= line_s1_q;
            start_s1_q <= start_move;
            start_s2_q <= start_s1_q;
        end
    end

`ifdef LINE_TRACKER_DEBOUNCE_EN
    localparam int unsigned DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    // filt_q is held in line polarity (1 = line), so it drives line_mask directly
    logic [N_SENSORS-1:0] filt_q, filt_d;
    logic [DB_W-1:0]      db_cnt_q [N_SENSORS];
    logic [DB_W-1:0]      db_cnt_d [N_SENSORS];

    // Per-bit debounce: flip only after DEBOUNCE consecutive differing samples
    always_comb begin
        filt_d = filt_q;
        for (int unsigned i = 0; i < N_SENSORS; i++) begin
            db_cnt_d[i] = '0;
            if (line_s2_q[i] != filt_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE - 1)) begin
                    filt_d[i] = line_s2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '0;
            for (int unsigned i = 0; i < N_SENSORS; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            for (int unsigned i = 0; i < N_SENSORS; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign mask_c = filt_q;
`else
    assign mask_c = line_s2_q;
`endif

    assign line_mask = mask_c;

    logic [2:0]      fsm_q, fsm_d;
    logic [LC_W-1:0] lost_cnt_q, lost_cnt_d;
    logic [1:0]      state_q, state_d;
    logic [1:0]      pre_state_q, pre_state_d;
    logic            lost_q, lost_d;
    logic [SC_W-1:0] l_cnt, r_cnt;
    logic [2:0]      cls_c;
    logic            none_c, only_center_c;

    // Side populations and straight-line classification of the filtered mask
    always_comb begin
        l_cnt = '0;
        r_cnt = '0;
        for (int unsigned i = 0; i < N_SENSORS; i++) begin
            if (mask_c[i] && i > CENTER) l_cnt = l_cnt + SC_W'(1);
            if (mask_c[i] && i < CENTER) r_cnt = r_cnt + SC_W'(1);
        end
        none_c        = (mask_c == '0);
        only_center_c = (mask_c == (N_SENSORS'(1) << CENTER));
        // Balanced masks (including the all-ones junction) count as centred
        if (none_c)             cls_c = S_SEARCH;
        else if (l_cnt > r_cnt) cls_c = S_LEFT;
        else if (r_cnt > l_cnt) cls_c = S_RIGHT;
        else                    cls_c = S_STRAIGHT;
    end

    // Next-state and registered-output decode
    always_comb begin
        fsm_d       = fsm_q;
        lost_cnt_d  = '0;
        state_d     = MOT_STOP;
        pre_state_d = pre_state_q;
        lost_d      = 1'b0;

        case (fsm_q)
            S_IDLE:     if (start_s2_q) fsm_d = S_STRAIGHT;
            S_STRAIGHT: fsm_d = cls_c;
            S_LEFT: begin
                if (none_c)              fsm_d = S_SEARCH;
                else if (r_cnt > l_cnt)  fsm_d = S_RIGHT;
                else if (only_center_c)  fsm_d = S_STRAIGHT;
            end
            S_RIGHT: begin
                if (none_c)              fsm_d = S_SEARCH;
                else if (l_cnt > r_cnt)  fsm_d = S_LEFT;
                else if (only_center_c)  fsm_d = S_STRAIGHT;
            end
            S_SEARCH: begin
                if (!none_c) begin
                    fsm_d = cls_c;
                end else if (lost_cnt_q == LC_W'(LOST_TIMEOUT - 1)) begin
                    fsm_d = S_HALT;
                end else begin
                    lost_cnt_d = (&lost_cnt_q) ? lost_cnt_q : lost_cnt_q + LC_W'(1);
                end
            end
            S_HALT:     fsm_d = S_HALT;
            default:    fsm_d = S_IDLE;
        endcase

        if (!start_s2_q) begin
            fsm_d      = S_IDLE;
            lost_cnt_d = '0;
        end

        if (fsm_d == S_LEFT && fsm_q != S_LEFT)   pre_state_d = MOT_LEFT;
        if (fsm_d == S_RIGHT && fsm_q != S_RIGHT) pre_state_d = MOT_RIGHT;

        case (fsm_d)
            S_STRAIGHT: state_d = MOT_STR;
            S_LEFT:     state_d = MOT_LEFT;
            S_RIGHT:    state_d = MOT_RIGHT;
            S_SEARCH:   state_d = pre_state_q;
            default:    state_d = MOT_STOP;
        endcase

        lost_d = (fsm_d == S_HALT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q       <= S_IDLE;
            lost_cnt_q  <= '0;
            state_q     <= MOT_STOP;
            pre_state_q <= MOT_LEFT;
            lost_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            lost_cnt_q  <= lost_cnt_d;
            state_q     <= state_d;
            pre_state_q <= pre_state_d;
            lost_q      <= lost_d;
        end
    end

    assign state     = state_q;
    assign pre_state = pre_state_q;
    assign lost      = lost_q;

endmodule

// File: tb/tb_line_tracker_ctrl.sv
// Directed bench for line_tracker_ctrl: a 3-sensor instance (LOST_TIMEOUT=8)
// and a 5-sensor instance sharing clock and reset.
module tb_line_tracker_ctrl;

`ifdef LINE_TRACKER_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [2:0] track = 3'b111;
    logic       start_move = 1'b0;
    logic [1:0] state, pre_state;
    logic       lost;
    logic [2:0] line_mask;

    logic [4:0] track5 = 5'b11111;
    logic       start5 = 1'b0;
    logic [1:0] state5, pre_state5;
    logic       lost5;
    logic [4:0] line_mask5;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    line_tracker_ctrl #(.N_SENSORS(3), .DEBOUNCE(4), .LOST_TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n), .track(track), .start_move(start_move),
        .state(state), .pre_state(pre_state), .lost(lost), .line_mask(line_mask)
    );

    line_tracker_ctrl #(.N_SENSORS(5), .DEBOUNCE(4), .LOST_TIMEOUT(8)) dut5 (
        .clk(clk), .reset_n(reset_n), .track(track5), .start_move(start5),
        .state(state5), .pre_state(pre_state5), .lost(lost5), .line_mask(line_mask5)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with no line under any sensor
        #2 reset_n = 1'b0;
        tick(3);
        check("rst_state", {6'b0, state}, 8'h00);
        check("rst_pre",   {6'b0, pre_state}, 8'h02);
        check("rst_lost",  {7'b0, lost}, 8'h00);
        check("rst_mask",  {5'b0, line_mask}, 8'h00);
        reset_n = 1'b1;

        // Centre line, then run
        track = 3'b101;
        tick(LAT + 2);
        check("idle_mask",  {5'b0, line_mask}, 8'h02);
        check("idle_state", {6'b0, state}, 8'h00);
        start_move = 1'b1;
        tick(3);
        check("go_straight", {6'b0, state}, 8'h03);

        // Line drifts left: mask latency then one more cycle for state
        track = 3'b011;
        tick(LAT);
        check("left_mask",      {5'b0, line_mask}, 8'h04);
        check("left_state_pre", {6'b0, state}, 8'h03);
        tick(1);
        check("left_state", {6'b0, state}, 8'h02);
        check("left_pre",   {6'b0, pre_state}, 8'h02);

        // Opposite side from LEFT goes directly to RIGHT
        track = 3'b110;
        tick(LAT + 1);
        check("l2r_state", {6'b0, state}, 8'h01);
        check("l2r_pre",   {6'b0, pre_state}, 8'h01);

        // Centre-only mask releases the turn
        track = 3'b101;
        tick(LAT + 1);
        check("r2s_state", {6'b0, state}, 8'h03);
        check("r2s_pre",   {6'b0, pre_state}, 8'h01);

`ifdef LINE_TRACKER_DEBOUNCE_EN
        // 3-cycle glitch is filtered out
        track = 3'b011;
        tick(3);
        track = 3'b101;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("glitch_mask",  {5'b0, line_mask}, 8'h02);
            check("glitch_state", {6'b0, state}, 8'h03);
        end
`else
        // Without the filter a 1-cycle glitch passes straight through
        track = 3'b011;
        tick(1);
        track = 3'b101;
        tick(1);
        check("glitch_mask", {5'b0, line_mask}, 8'h04);
        tick(1);
        check("glitch_left", {6'b0, state}, 8'h02);
        tick(1);
        check("glitch_back", {6'b0, state}, 8'h03);
`endif

        // Junction: all sensors on the line keeps going straight
        track = 3'b000;
        tick(LAT + 1);
        check("junc_mask",  {5'b0, line_mask}, 8'h07);
        check("junc_state", {6'b0, state}, 8'h03);
        tick(3);
        check("junc_hold", {6'b0, state}, 8'h03);

        // Right turn from the junction
        track = 3'b110;
        tick(LAT + 1);
        check("right_state", {6'b0, state}, 8'h01);
        check("right_pre",   {6'b0, pre_state}, 8'h01);

        // Line lost: SEARCH repeats last turn for 8 cycles then HALT
        track = 3'b111;
        tick(LAT);
        check("lost_mask",  {5'b0, line_mask}, 8'h00);
        check("lost_right", {6'b0, state}, 8'h01);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("search_state", {6'b0, state}, 8'h01);
            check("search_lost",  {7'b0, lost}, 8'h00);
        end
        tick(1);
        check("halt_state", {6'b0, state}, 8'h00);
        check("halt_lost",  {7'b0, lost}, 8'h01);

        // HALT ignores a reappearing line
        track = 3'b101;
        tick(LAT + 2);
        check("halt_hold_state", {6'b0, state}, 8'h00);
        check("halt_hold_lost",  {7'b0, lost}, 8'h01);

        // start_move low reaches the FSM after the synchroniser
        start_move = 1'b0;
        tick(2);
        check("stop_lat_lost", {7'b0, lost}, 8'h01);
        tick(1);
        check("idle_lost",  {7'b0, lost}, 8'h00);
        check("idle_state2", {6'b0, state}, 8'h00);
        start_move = 1'b1;
        tick(2);
        check("restart_lat", {6'b0, state}, 8'h00);
        tick(1);
        check("restart", {6'b0, state}, 8'h03);

        // Enter SEARCH then reset asynchronously between clock edges
        track = 3'b111;
        tick(LAT + 1);
        check("search2_state", {6'b0, state}, 8'h01);
        #2 reset_n = 1'b0;
        #1;
        check("arst_state", {6'b0, state}, 8'h00);
        check("arst_pre",   {6'b0, pre_state}, 8'h02);
        check("arst_lost",  {7'b0, lost}, 8'h00);
        check("arst_mask",  {5'b0, line_mask}, 8'h00);
        tick(2);
        reset_n = 1'b1;

        // Five-sensor instance
        track5 = 5'b11011;
        tick(LAT + 2);
        check("n5_mask_c", {3'b0, line_mask5}, 8'h04);
        start5 = 1'b1;
        tick(3);
        check("n5_straight", {6'b0, state5}, 8'h03);
        track5 = 5'b10111;
        tick(LAT);
        check("n5_mask_l", {3'b0, line_mask5}, 8'h08);
        tick(1);
        check("n5_left", {6'b0, state5}, 8'h02);
        check("n5_pre",  {6'b0, pre_state5}, 8'h02);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
